disp_scan4: RTL

DISP_SCAN4 -- requirements
Module: disp_scan4

---
 rtl/disp_scan4.sv | 105 ++++++++++
 1 files changed

// File: rtl/disp_scan4.sv
// rtl/disp_scan4.sv - four-digit multiplexed hex display scanner
// Double-buffered display value, anode dead time and leading-zero blanking.
module disp_scan4 #(
  parameter int DIV  = 50000,
  parameter int DEAD = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic        lz_en,
  output logic [3:0]  nibble_out,
  output logic [3:0]  an_out,
  output logic [1:0]  digit_idx,
  output logic        frame_tick
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PLAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PDEAD = PW'(DEAD);

  logic [PW-1:0] presc;
  logic [1:0]    digit;
  logic [15:0]   shadow;
  logic [15:0]   pend_data;
  logic          pend;
  logic          presc_last;
  logic          wrap;
  logic          suppressed;
  logic          z3, z2, z1;

  assign presc_last = (presc == PLAST);
  assign wrap       = presc_last && (digit == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc      <= '0;
      digit      <= 2'd0;
      shadow     <= 16'h0000;
      pend_data  <= 16'h0000;
      pend       <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      presc      <= presc_last ? '0 : presc + 1'b1;
      frame_tick <= wrap;
      if (presc_last) begin
        digit <= digit + 2'd1;
      end
      // The shadow only moves at the frame boundary; a load landing on the
      // boundary itself goes straight to the shadow and beats any pending value.
      if (wrap) begin
        if (load) begin
          shadow <= data_in;
          pend   <= 1'b0;
        end else if (pend) begin
          shadow <= pend_data;
          pend   <= 1'b0;
        end
      end else if (load) begin
        pend_data <= data_in;
        pend      <= 1'b1;
      end
    end
  end

  assign z3 = (shadow[15:12] == 4'h0);
  assign z2 = (shadow[11:8]  == 4'h0);
  assign z1 = (shadow[7:4]   == 4'h0);

  always_comb begin
    nibble_out = 4'h0;
    suppressed = 1'b0;
    case (digit)
      2'd0: nibble_out = shadow[3:0];
      2'd1: begin
        nibble_out = shadow[7:4];
        suppressed = z3 && z2 && z1;
      end
      2'd2: begin
        nibble_out = shadow[11:8];
        suppressed = z3 && z2;
      end
      default: begin
        nibble_out = shadow[15:12];
        suppressed = z3;
      end
    endcase
  end

  assign digit_idx = digit;

  // lz_en is applied combinationally so blanking follows it without waiting a frame.
  always_comb begin
    an_out = 4'b1111;
    if (!(presc < PDEAD) && !(lz_en && suppressed)) begin
      case (digit)
        2'd0:    an_out = 4'b1110;
        2'd1:    an_out = 4'b1101;
        2'd2:    an_out = 4'b1011;
        default: an_out = 4'b0111;
      endcase
    end
  end

endmodule
